// File: rtl/alu_div_sequencer.sv
// Multi-cycle radix-2 restoring divider for div/divu/rem/remu.
// Optional result reuse cache: define DIV_RESULT_REUSE_EN.
module alu_div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] OP_DIV  = 5'b01110;
    localparam logic [4:0] OP_DIVU = 5'b01111;
    localparam logic [4:0] OP_REM  = 5'b10000;
    localparam logic [4:0] OP_REMU = 5'b10001;

    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES  = '1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

    logic [1:0]      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] r_q, q_q, bmag_q;
    logic            sa_q, sb_q, sel_q;
    logic [XLEN-1:0] quo_q, rem_q;
    logic            out_rem_q;

    logic is_div, sgn_in, sel_in;

    always_comb begin
        is_div = 1'b0;
        sgn_in = 1'b0;
        sel_in = 1'b0;
        case (alu_op_i)
            OP_DIV:  begin is_div = 1'b1; sgn_in = 1'b1; end
            OP_DIVU: begin is_div = 1'b1; end
            OP_REM:  begin is_div = 1'b1; sgn_in = 1'b1; sel_in = 1'b1; end
            OP_REMU: begin is_div = 1'b1; sel_in = 1'b1; end
            default: ;
        endcase
    end

    logic            a_neg, b_neg, b_zero, ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg  = sgn_in & op_a_i[XLEN-1];
    assign b_neg  = sgn_in & op_b_i[XLEN-1];
    assign a_mag  = a_neg ? -op_a_i : op_a_i;
    assign b_mag  = b_neg ? -op_b_i : op_b_i;
    assign b_zero = (op_b_i == '0);
    assign ovf    = sgn_in & (op_a_i == MIN_S) & (op_b_i == ONES);
    assign accept = (state_q == S_IDLE) & req_i & is_div & ~flush_i;

    // Partial remainder is XLEN+1 bits only transiently; the top bit of
    // the difference doubles as the "remainder < divisor" flag.
    logic [XLEN:0]   r_sh, diff;
    logic            ge;
    logic [XLEN-1:0] r_n, q_n, quo_fin, rem_fin;

    assign r_sh    = {r_q, q_q[XLEN-1]};
    assign diff    = r_sh - {1'b0, bmag_q};
    assign ge      = ~diff[XLEN];
    assign r_n     = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    assign q_n     = {q_q[XLEN-2:0], ge};
    assign quo_fin = (sa_q ^ sb_q) ? -q_n : q_n;
    assign rem_fin = sa_q ? -r_n : r_n;

    logic            hit;
    logic [XLEN-1:0] hit_quo, hit_rem;

`ifdef DIV_RESULT_REUSE_EN
    logic            c_vld_q, c_sgn_q, sgn_q;
    logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q, a_q, b_q;

    assign hit = c_vld_q & (c_a_q == op_a_i) & (c_b_q == op_b_i)
               & (c_sgn_q == sgn_in);
    assign hit_quo = c_quo_q;
    assign hit_rem = c_rem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_vld_q <= 1'b0;
            c_sgn_q <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_quo_q <= '0;
            c_rem_q <= '0;
            sgn_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            if (accept) begin
                sgn_q <= sgn_in;
                a_q   <= op_a_i;
                b_q   <= op_b_i;
            end
            if (state_q == S_DONE && !flush_i) begin
                c_vld_q <= 1'b1;
                c_sgn_q <= sgn_q;
                c_a_q   <= a_q;
                c_b_q   <= b_q;
                c_quo_q <= quo_q;
                c_rem_q <= rem_q;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_quo = '0;
    assign hit_rem = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            bmag_q    <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            sel_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            out_rem_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sel_q  <= sel_in;
                        sa_q   <= a_neg;
                        sb_q   <= b_neg;
                        bmag_q <= b_mag;
                        r_q    <= '0;
                        q_q    <= a_mag;
                        cnt_q  <= '0;
                        if (hit) begin
                            quo_q     <= hit_quo;
                            rem_q     <= hit_rem;
                            out_rem_q <= sel_in;
                            state_q   <= S_DONE;
                        end else if (b_zero) begin
                            quo_q     <= ONES;
                            rem_q     <= op_a_i;
                            out_rem_q <= sel_in;
                            state_q   <= S_DONE;
                        end else if (ovf) begin
                            quo_q     <= MIN_S;
                            rem_q     <= '0;
                            out_rem_q <= sel_in;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        r_q   <= r_n;
                        q_q   <= q_n;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            quo_q     <= quo_fin;
                            rem_q     <= rem_fin;
                            out_rem_q <= sel_q;
                            state_q   <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign stall_o  = accept | (state_q == S_CALC);
    assign valid_o  = (state_q == S_DONE) & ~flush_i;
    assign result_o = out_rem_q ? rem_q : quo_q;

endmodule
